// File: rtl/i2s_master_rx.sv
`timescale 1ns/1ps
// i2s_master_rx: I2S master receiver. The SCK and WS outputs are generated from
// clk by a divider, and i2s_sd is captured MSB-first in standard I2S format
// (one SCK of delay after each WS change). Each completed frame is presented on
// a valid/ready interface. The whole block runs on clk. SCK is a registered
// output and is never used as a clock inside the block.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high; takes priority over all other inputs
//   enable        1 = run SCK/WS and capture; 0 = idle, clear the serial path
//   i2s_sd        serial data from the microphone (already synchronised)
//   i2s_sck       bit clock, registered
//   i2s_ws        word select, registered; 0 = left slot, 1 = right slot
//   left_data     left sample, MSB-aligned two's complement
//   right_data    right sample; constant 0 when STEREO = 0
//   sample_valid  a frame is waiting on left_data/right_data
//   sample_ready  the consumer takes the frame on a clk where valid & ready
//   overrun       sticky flag: a frame was overwritten before it was accepted
//   overrun_clr   clears overrun; a new overrun event in the same clk wins
module i2s_master_rx #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned SLOT_SIZE = 32,
  parameter int unsigned STEREO    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 i2s_sd,
  output logic                 i2s_sck,
  output logic                 i2s_ws,
  output logic [DATA_SIZE-1:0] left_data,
  output logic [DATA_SIZE-1:0] right_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  // The counter must be able to hold SLOT_SIZE, the value it reaches after the last rise.
  localparam int unsigned CNT_W = $clog2(SLOT_SIZE + 1);

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 sck_q, sck_d;
  logic                 ws_q, ws_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic [DATA_SIZE-1:0] left_q, left_d;
  logic [DATA_SIZE-1:0] right_q, right_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;

  logic                 rise_c;
  logic                 fall_c;
  logic                 bit_en_c;
  logic                 last_c;
  logic                 frame_done_c;
  logic [DATA_SIZE-1:0] shift_next_c;

  // SCK divider: the counter wraps at CLK_DIV-1 and toggles SCK.
  always_comb begin
    div_d  = div_q;
    sck_d  = sck_q;
    rise_c = 1'b0;
    fall_c = 1'b0;
    if (!enable) begin
      div_d = '0;
      sck_d = 1'b0;
    end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d  = '0;
      sck_d  = ~sck_q;
      rise_c = ~sck_q;
      fall_c = sck_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Slot counter and WS.
  // cnt_q is the index r of the next rise within the slot.
  // WS toggles on the fall that follows rise r = SLOT_SIZE-1.
  always_comb begin
    cnt_d = cnt_q;
    ws_d  = ws_q;
    if (!enable) begin
      cnt_d = '0;
      ws_d  = 1'b0;
    end else if (rise_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (fall_c && (cnt_q == CNT_W'(SLOT_SIZE))) begin
      cnt_d = '0;
      ws_d  = ~ws_q;
    end
  end

  // Capture: data is shifted in on rises r = 1..DATA_SIZE. Rise r = 0 carries
  // the I2S one-bit delay, and the rises after DATA_SIZE are padding.
  always_comb begin
    bit_en_c     = rise_c && (cnt_q >= CNT_W'(1)) && (cnt_q <= CNT_W'(DATA_SIZE));
    last_c       = rise_c && (cnt_q == CNT_W'(DATA_SIZE));
    shift_next_c = (shift_q << 1) | DATA_SIZE'(i2s_sd);
    // A frame is complete at the end of the right word, or at the end of the left word in mono mode.
    frame_done_c = last_c && ((STEREO != 0) ? ws_q : ~ws_q);
    shift_d      = shift_q;
    hold_d       = hold_q;
    if (!enable) begin
      shift_d = '0;
      hold_d  = '0;
    end else begin
      if (bit_en_c) begin
        shift_d = shift_next_c;
      end
      if (last_c && !ws_q) begin
        hold_d = shift_next_c;
      end
    end
  end

  // Output frame register, valid/ready handshake and sticky overrun flag.
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
    if (overrun_clr) begin
      ovr_d = 1'b0;
    end
    if (frame_done_c) begin
      valid_d = 1'b1;
      if (STEREO != 0) begin
        left_d  = hold_q;
        right_d = shift_next_c;
      end else begin
        left_d = shift_next_c;
      end
      // A frame is overwritten only if it was neither accepted nor drained in this clk.
      if (valid_q && !sample_ready) begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign i2s_sck      = sck_q;
  assign i2s_ws       = ws_q;
  assign left_data    = left_q;
  assign right_data   = right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_i2s_master_rx.sv
`timescale 1ns/1ps
// Testbench for i2s_master_rx.
// The stereo instance uses CLK_DIV=2, DATA_SIZE=16, SLOT_SIZE=32.
// The mono instance uses CLK_DIV=2, DATA_SIZE=24, SLOT_SIZE=32.
// Each instance is driven by a microphone model that follows the DUT's SCK/WS.
module tb_i2s_master_rx;

  logic        clk = 1'b0;
  logic        rst, en, sd, sck, ws, valid, ready, ovr, ovr_clr;
  logic [15:0] ld, rd;
  logic        en_m, sd_m, sck_m, ws_m, valid_m, ready_m, ovr_m, ovr_clr_m;
  logic [23:0] ld_m, rd_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2s_master_rx #(.CLK_DIV(2), .DATA_SIZE(16), .SLOT_SIZE(32), .STEREO(1)) u_st (
    .clk(clk), .rst(rst), .enable(en), .i2s_sd(sd), .i2s_sck(sck), .i2s_ws(ws),
    .left_data(ld), .right_data(rd), .sample_valid(valid), .sample_ready(ready),
    .overrun(ovr), .overrun_clr(ovr_clr)
  );

  i2s_master_rx #(.CLK_DIV(2), .DATA_SIZE(24), .SLOT_SIZE(32), .STEREO(0)) u_mo (
    .clk(clk), .rst(rst), .enable(en_m), .i2s_sd(sd_m), .i2s_sck(sck_m), .i2s_ws(ws_m),
    .left_data(ld_m), .right_data(rd_m), .sample_valid(valid_m), .sample_ready(ready_m),
    .overrun(ovr_m), .overrun_clr(ovr_clr_m)
  );

  // Stereo microphone: latches the next frame at each left-slot start and
  // changes SD after each SCK fall. Fall k after a slot start carries bit 16-k.
  logic [15:0] nxt_l, nxt_r, cur_l = '0, cur_r = '0, w_s;
  int          fcnt = 0;
  logic        sck_p = 1'b0, ws_p = 1'b0;
  always @(negedge clk) begin
    if (sck_p && !sck) begin
      if (ws != ws_p) begin
        fcnt = 0;
        if (!ws) begin cur_l = nxt_l; cur_r = nxt_r; end
      end else begin
        fcnt = fcnt + 1;
      end
    end
    if (rst || !en) begin fcnt = 0; cur_l = nxt_l; cur_r = nxt_r; end
    w_s = ws ? cur_r : cur_l;
    sd  = (fcnt >= 1 && fcnt <= 16) ? w_s[4'(16 - fcnt)] : 1'b0;
    sck_p = sck;
    ws_p  = ws;
  end

  // Mono microphone: sends a 24-bit left word and drives 1s through the right
  // slot, which the DUT must ignore.
  logic [23:0] nxt_m, cur_m = '0;
  int          fcnt_m = 0;
  logic        sck_pm = 1'b0, ws_pm = 1'b0;
  always @(negedge clk) begin
    if (sck_pm && !sck_m) begin
      if (ws_m != ws_pm) begin
        fcnt_m = 0;
        if (!ws_m) cur_m = nxt_m;
      end else begin
        fcnt_m = fcnt_m + 1;
      end
    end
    if (rst || !en_m) begin fcnt_m = 0; cur_m = nxt_m; end
    sd_m   = ws_m ? 1'b1 : ((fcnt_m >= 1 && fcnt_m <= 24) ? cur_m[5'(24 - fcnt_m)] : 1'b0);
    sck_pm = sck_m;
    ws_pm  = ws_m;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Waits at most 600 clk for sample_valid on the selected instance.
  task automatic wait_valid(input string name, input bit mono);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mono ? valid_m : valid) && n < 600);
    if (!(mono ? valid_m : valid)) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=no_valid required=valid_within_600clk", name);
    end
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int hb, ws_tog, ws_mis, ws_int_bad, rises, vcnt, run, last_tog, n;
    bit first_tr;
    logic ps, pw;

    vecs[0] = '{l: 16'hFFFF, r: 16'h0000, el: 16'hFFFF, er: 16'h0000};
    vecs[1] = '{l: 16'h8000, r: 16'h7FFF, el: 16'h8000, er: 16'h7FFF};
    vecs[2] = '{l: 16'h0F0F, r: 16'hF0F0, el: 16'h0F0F, er: 16'hF0F0};
    vecs[3] = '{l: 16'h0001, r: 16'h8001, el: 16'h0001, er: 16'h8001};

    rst = 1'b1; en = 1'b0; ready = 1'b1; ovr_clr = 1'b0;
    en_m = 1'b0; ready_m = 1'b1; ovr_clr_m = 1'b0;
    nxt_l = 16'hA5C3; nxt_r = 16'h1234; nxt_m = 24'h800001;
    repeat (3) @(negedge clk);
    check("rst_sck", 32'(sck), 0);
    check("rst_ws", 32'(ws), 0);
    check("rst_left", 32'(ld), 0);
    check("rst_right", 32'(rd), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_overrun", 32'(ovr), 0);
    check("rst_mono_valid", 32'(valid_m), 0);
    rst = 1'b0;
    en  = 1'b1;

    // Basic stereo capture of the first complete frame.
    wait_valid("first_frame", 1'b0);
    check("first_left", 32'(ld), 32'hA5C3);
    check("first_right", 32'(rd), 32'h1234);

    // Clock timing over 512 clk: 50% duty at 4 clk per SCK, WS toggles only on SCK falls every 128 clk.
    hb = 0; ws_tog = 0; ws_mis = 0; ws_int_bad = 0; rises = 0; vcnt = 0;
    run = 0; last_tog = -1; first_tr = 1'b1; ps = sck; pw = ws;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (sck != ps) begin
        if (!first_tr && run != 2) hb++;
        first_tr = 1'b0;
        run = 1;
        if (sck) rises++;
      end else begin
        run++;
      end
      if (ws != pw) begin
        ws_tog++;
        if (!(ps && !sck)) ws_mis++;
        if (last_tog >= 0 && (i - last_tog) != 128) ws_int_bad++;
        last_tog = i;
      end
      if (valid) vcnt++;
      if (valid && (ld !== 16'hA5C3 || rd !== 16'h1234)) vcnt += 100;
      ps = sck;
      pw = ws;
    end
    check("sck_half_period_errors", 32'(hb), 0);
    check("sck_rises_per_512clk", 32'(rises), 128);
    check("ws_toggles_per_512clk", 32'(ws_tog), 4);
    check("ws_toggle_not_on_sck_fall", 32'(ws_mis), 0);
    check("ws_interval_errors", 32'(ws_int_bad), 0);
    check("valid_cycles_per_2frames", 32'(vcnt), 2);

    // Table-driven frames. Each vector is loaded at a valid pulse and is returned by the next frame.
    for (int i = 0; i < 4; i++) begin
      nxt_l = vecs[i].l;
      nxt_r = vecs[i].r;
      wait_valid($sformatf("vec%0d_valid", i), 1'b0);
      check($sformatf("vec%0d_left", i), 32'(ld), 32'(vecs[i].el));
      check($sformatf("vec%0d_right", i), 32'(rd), 32'(vecs[i].er));
    end
    @(negedge clk);
    check("valid_one_clk_pulse", 32'(valid), 0);

    // Backpressure: F1 is held, F2 overwrites it, and overrun_clr coincides with the overrun event.
    nxt_l = 16'h0001; nxt_r = 16'h0002; ready = 1'b0;
    wait_valid("bp_f1_valid", 1'b0);
    check("bp_f1_left", 32'(ld), 32'h0001);
    check("bp_f1_right", 32'(rd), 32'h0002);
    check("bp_f1_no_overrun", 32'(ovr), 0);
    nxt_l = 16'h0003; nxt_r = 16'h0004;
    repeat (255) @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("bp_overrun_set_wins", 32'(ovr), 1);
    check("bp_valid_held", 32'(valid), 1);
    check("bp_f2_left", 32'(ld), 32'h0003);
    check("bp_f2_right", 32'(rd), 32'h0004);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("bp_overrun_cleared", 32'(ovr), 0);
    check("bp_valid_still_held", 32'(valid), 1);
    ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drops", 32'(valid), 0);

    // Enable dropped in the middle of the right slot (ws is 1 at this point).
    check("dis_ws_before", 32'(ws), 1);
    en = 1'b0;
    @(negedge clk);
    check("dis_sck", 32'(sck), 0);
    check("dis_ws", 32'(ws), 0);
    check("dis_left_held", 32'(ld), 32'h0003);
    nxt_l = 16'h7FFF; nxt_r = 16'h8000;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid || sck || ws) n++;
    end
    check("dis_idle_activity", 32'(n), 0);
    en = 1'b1;
    wait_valid("reen_valid", 1'b0);
    check("reen_left", 32'(ld), 32'h7FFF);
    check("reen_right", 32'(rd), 32'h8000);

    // Reset near r=10 of the left slot, with a frame held valid.
    ready = 1'b0;
    n = 0;
    while (ws && n < 300) begin @(negedge clk); n++; end
    check("rst_wait_left_slot", 32'(ws), 0);
    repeat (42) @(negedge clk);
    rst = 1'b1;
    nxt_l = 16'h1357; nxt_r = 16'h2468;
    @(negedge clk);
    check("mrst_sck", 32'(sck), 0);
    check("mrst_ws", 32'(ws), 0);
    check("mrst_left", 32'(ld), 0);
    check("mrst_right", 32'(rd), 0);
    check("mrst_valid", 32'(valid), 0);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    wait_valid("mrst_next_valid", 1'b0);
    check("mrst_next_left", 32'(ld), 32'h1357);
    check("mrst_next_right", 32'(rd), 32'h2468);

    // Mono, 24-bit.
    en_m = 1'b1;
    wait_valid("mono_f1_valid", 1'b1);
    check("mono_f1_left", 32'(ld_m), 32'h800001);
    check("mono_f1_right", 32'(rd_m), 0);
    nxt_m = 24'h7FFFFE;
    wait_valid("mono_f2_valid", 1'b1);
    check("mono_f2_left", 32'(ld_m), 32'h7FFFFE);
    check("mono_f2_right", 32'(rd_m), 0);
    vcnt = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (valid_m) vcnt++;
      if (rd_m !== 24'h0 || ld_m !== 24'h7FFFFE) vcnt += 100;
    end
    check("mono_valid_cycles_per_2frames", 32'(vcnt), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish_before_2ms");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
